// File: rtl/seq111_detector_if.sv
// Signal bundle between a bit-stream source and the 1-1-1 sequence detector.
// The source drives the qualified bit and clear; the detector returns its status.
interface seq111_detector_if #(
    parameter int CNT_W = 8
);
    logic             clr;
    logic             in_valid;
    logic             in_bit;
    logic             detect;
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             sat;

    modport master (
        output clr, in_valid, in_bit,
        input  detect, state, count, sat
    );

    modport slave (
        input  clr, in_valid, in_bit,
        output detect, state, count, sat
    );
endinterface

// File: rtl/seq111_detector.sv
// Detects three consecutive valid '1' bits on a serial stream, pulses detect one
// clock after the third sampling edge and keeps a saturating detection count.
module seq111_detector #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seq111_detector_if.slave bus
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_detect;
    logic             w_detect_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S0;
            r_detect <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_detect <= w_detect_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Invalid cycles leave the run untouched, so gaps never break consecutiveness.
    always_comb begin
        w_state_nxt  = r_state;
        w_detect_nxt = 1'b0;
        w_count_nxt  = r_count;
        if (bus.clr) begin
            w_state_nxt = S0;
            w_count_nxt = '0;
        end else if (bus.in_valid) begin
            if (!bus.in_bit) begin
                w_state_nxt = S0;
            end else begin
                case (r_state)
                    S0: w_state_nxt = S1;
                    S1: w_state_nxt = S2;
                    S2: begin
                        w_state_nxt  = S3;
                        w_detect_nxt = 1'b1;
                    end
                    default: begin
                        if (OVERLAP != 0) begin
                            w_state_nxt  = S3;
                            w_detect_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S1;
                        end
                    end
                endcase
            end
            if (w_detect_nxt) begin
                w_count_nxt = sat_inc(r_count);
            end
        end
    end

    assign bus.detect = r_detect;
    assign bus.state  = r_state;
    assign bus.count  = r_count;
    assign bus.sat    = (r_count == CNT_MAX);

endmodule

// File: tb/tb_seq111_detector.sv
// Scoreboard bench for seq111_detector: three configurations share one random/directed
// stream, a run-length reference model queues expectations and a monitor checks them.
module tb_seq111_detector;

    typedef struct packed {
        logic       d;
        logic [1:0] s;
        logic [7:0] c;
        logic       sat;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq111_detector_if #(.CNT_W(8)) if0 ();
    seq111_detector_if #(.CNT_W(8)) if1 ();
    seq111_detector_if #(.CNT_W(2)) if2 ();

    seq111_detector #(.OVERLAP(1), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seq111_detector #(.OVERLAP(0), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq111_detector #(.OVERLAP(1), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int    n_checks = 0;
    int    n_fail   = 0;
    exp3_t q[$];

    // Reference: length of the current run of valid ones and number of detections.
    int run[3];
    int det[3];
    int ov[3]   = '{1, 0, 1};
    int maxc[3] = '{255, 255, 3};

    function automatic exp_t actual(int k);
        exp_t a;
        case (k)
            0: a = '{d: if0.detect, s: if0.state, c: if0.count, sat: if0.sat};
            1: a = '{d: if1.detect, s: if1.state, c: if1.count, sat: if1.sat};
            default: a = '{d: if2.detect, s: if2.state, c: 8'(if2.count), sat: if2.sat};
        endcase
        return a;
    endfunction

    task automatic chk(string name, int k, exp_t a, exp_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got det=%0b st=%0d cnt=%0d sat=%0b, want det=%0b st=%0d cnt=%0d sat=%0b",
                     name, k, $time, a.d, a.s, a.c, a.sat, e.d, e.s, e.c, e.sat);
        end
    endtask

    function automatic exp_t model_step(int k, logic rn, logic c, logic v, logic b);
        exp_t e;
        int   cnt;
        logic hit = 1'b0;
        if (!rn || c) begin
            run[k] = 0;
            det[k] = 0;
        end else if (v) begin
            if (!b) run[k] = 0;
            else begin
                run[k]++;
                hit = (ov[k] != 0) ? (run[k] >= 3) : (run[k] % 3 == 0);
                if (hit) det[k]++;
            end
        end
        cnt   = (det[k] > maxc[k]) ? maxc[k] : det[k];
        e.d   = hit;
        if (ov[k] != 0) e.s = 2'((run[k] > 3) ? 3 : run[k]);
        else            e.s = 2'((run[k] == 0) ? 0 : ((run[k] - 1) % 3) + 1);
        e.c   = 8'(cnt);
        e.sat = (cnt == maxc[k]);
        return e;
    endfunction

    task automatic step(input logic rn, input logic c, input logic v, input logic b);
        exp3_t e;
        @(negedge clk);
        rst_n = rn;
        if0.clr = c; if0.in_valid = v; if0.in_bit = b;
        if1.clr = c; if1.in_valid = v; if1.in_bit = b;
        if2.clr = c; if2.in_valid = v; if2.in_bit = b;
        for (int k = 0; k < 3; k++) e[k] = model_step(k, rn, c, v, b);
        q.push_back(e);
    endtask

    task automatic bits(input logic [15:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b0, 1'b1, pat[i]);
    endtask

    // Reset pulled low between edges must clear the outputs without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("async_rst", k, actual(k), '0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp3_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) chk("cycle", k, actual(k), e[k]);
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        if0.clr = 0; if0.in_valid = 0; if0.in_bit = 0;
        if1.clr = 0; if1.in_valid = 0; if1.in_bit = 0;
        if2.clr = 0; if2.in_valid = 0; if2.in_bit = 0;
        #1;
        for (int k = 0; k < 3; k++) chk("reset_state", k, actual(k), '0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);   // first edge after release samples normally
        bits(16'b11, 2);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        bits(16'b11111, 5);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        bits(16'b110111, 6);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        bits(16'b1, 1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);
        bits(16'b11, 2);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        bits(16'b11, 2);
        step(1'b1, 1'b1, 1'b1, 1'b1);   // clear wins over a detecting bit
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(16'b11, 2);
        async_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(16'b11, 2);
        bits(16'b1111, 4);
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 75),
                 ($urandom_range(0, 99) < 75));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq111_detector.md
SEQ111_DETECTOR -- requirements
Module: seq111_detector

Interface
REQ-001 Parameter OVERLAP, default 1: 1 allows overlapping detections; 0 requires three fresh ones after each detection.
REQ-002 Parameter CNT_W, default 8: width of the detection counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clr  input  1  synchronous clear of FSM and counter.
REQ-006 in_valid  input  1  in_bit qualifier; sampled only when high.
REQ-007 in_bit  input  1  serial data bit.
REQ-008 detect  output  1  one-cycle pulse, three consecutive valid ones seen.
REQ-009 state  output  2  current FSM state, for debug.
REQ-010 count  output  CNT_W  number of detections since reset/clr, saturating.
REQ-011 sat  output  1  high while count equals 2^CNT_W-1.

Function
REQ-012 The FSM SHALL have states S0=2'd0 (no ones), S1=2'd1 (one 1), S2=2'd2 (two 1s) and S3=2'd3 (detected).
REQ-013 Cycle with in_valid=0 and clr=0: state and count SHALL hold, and detect SHALL be 0 next cycle.
REQ-014 Valid 0: next state SHALL be S0 from any state.
REQ-015 Valid 1: S0->S1, S1->S2, S2->S3.
REQ-016 Valid 1 in S3 with OVERLAP=1: state SHALL stay S3 and the FSM SHALL detect again.
REQ-017 Valid 1 in S3 with OVERLAP=0: next state SHALL be S1 with no detection.
REQ-018 detect SHALL be registered: high for exactly the one cycle after the edge that samples a detecting bit, low otherwise.
REQ-019 Detection latency SHALL be one clock from the sampling edge of the third 1 to detect high.
REQ-020 count SHALL increment by 1 on each detection, in the same edge that sets detect.
REQ-021 count SHALL saturate at 2^CNT_W-1 with no wrap; detect SHALL still pulse when saturated.
REQ-022 sat SHALL be combinational from count.
REQ-023 clr=1 SHALL force state=S0, count=0 and detect=0 on the next edge.
REQ-024 clr SHALL take priority over in_valid in the same cycle, and the in_bit of that cycle SHALL be discarded.
REQ-025 Gaps of in_valid=0 between ones SHALL NOT break a run: consecutiveness counts valid samples only.

Reset
REQ-026 While rst_n=0, state SHALL be S0, detect 0, count 0 and sat 0, immediately and independent of clk.
REQ-027 Reset asserted mid-run (S1/S2/S3) SHALL discard the partial run, and after release three new valid ones SHALL be needed for a detection.
REQ-028 Deassertion of rst_n SHALL be synchronous to clk.
REQ-029 The first edge after release SHALL sample inputs normally.

Verification
REQ-030 Valid bits 1,1,1 on consecutive cycles -> detect=1 one cycle after the third edge, count=1, state=S3.
REQ-031 OVERLAP=1, valid bits 1,1,1,1,1 -> three detect pulses on consecutive cycles, count=3; the same bits with OVERLAP=0 -> one pulse, count=1, state=S2 at end.
REQ-032 Bits 1,1,0,1,1,1 -> exactly one detect, after the sixth bit; 1,(in_valid=0 x4),1,1 -> one detect.
REQ-033 CNT_W=2, five detections -> count sequence 1,2,3,3,3, sat=1 from the third, detect pulses on all five.
REQ-034 clr=1 with in_valid=1, in_bit=1 in state S2 -> next cycle state=S0, count=0, detect=0.
REQ-035 rst_n pulled low between clock edges in S2 -> outputs zero immediately; after release, 1,1 -> no detect, state=S2.
